// File: rtl/snake_body_engine.sv
// Snake body store, stepper, self-collision scanner and per-pixel renderer for the VGA snake game.
// Optional build macro SNAKE_WALL_KILL_EN: leaving the grid kills the snake instead of wrapping.
module snake_body_engine #(
  parameter int GRID_W     = 160,
  parameter int GRID_H     = 120,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int CELL_SHIFT = 2,
  parameter int MAX_LEN    = 32,
  parameter int INIT_LEN   = 4,
  parameter int START_X    = 80,
  parameter int START_Y    = 60
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           STEP,
  input  logic [1:0]     DIRECTION,
  input  logic [X_W-1:0] TARGET_X,
  input  logic [Y_W-1:0] TARGET_Y,
  input  logic [9:0]     PIX_X,
  input  logic [8:0]     PIX_Y,
  output logic           PIX_ON,
  output logic [X_W-1:0] HEAD_X,
  output logic [Y_W-1:0] HEAD_Y,
  output logic [5:0]     LENGTH,
  output logic           TARGET_REACHED,
  output logic           BUSY,
  output logic           GAME_OVER
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam int IDX_W = $clog2(MAX_LEN);

  localparam logic [X_W-1:0] X_LAST   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0] X_START  = X_W'(START_X);
  localparam logic [Y_W-1:0] Y_START  = Y_W'(START_Y);
  localparam logic [X_W-1:0] X_ZERO   = {X_W{1'b0}};
  localparam logic [Y_W-1:0] Y_ZERO   = {Y_W{1'b0}};
  localparam logic [5:0]     LEN_INIT = 6'(INIT_LEN);
  localparam logic [5:0]     LEN_MAX  = 6'(MAX_LEN);

  logic [X_W-1:0]   seg_x_r [MAX_LEN];
  logic [Y_W-1:0]   seg_y_r [MAX_LEN];
  logic [1:0]       heading_r;
  logic [1:0]       state_r;
  logic [IDX_W-1:0] idx_r;
  logic [5:0]       length_r;
  logic             busy_r;
  logic             game_over_r;
  logic             target_hit_r;
  logic             pix_on_r;

  logic [1:0]       heading_nxt_s;
  logic [X_W-1:0]   new_x_s;
  logic [Y_W-1:0]   new_y_s;
  logic             hit_target_s;
  logic             scan_hit_s;
  logic             scan_last_s;
  logic             wall_kill_s;
  logic [9:0]       pix_cx_s;
  logic [8:0]       pix_cy_s;
  logic             in_grid_s;
  logic             pix_hit_s;

  // Heading update: a request for the exact reverse direction is ignored.
  always_comb begin
    if (DIRECTION == (heading_r ^ 2'd2)) begin
      heading_nxt_s = heading_r;
    end else begin
      heading_nxt_s = DIRECTION;
    end
  end

  // Next head cell, wrapping modulo the grid rather than modulo the field width.
  always_comb begin
    new_x_s = seg_x_r[0];
    new_y_s = seg_y_r[0];
    case (heading_nxt_s)
      2'd0: begin
        if (seg_y_r[0] == Y_ZERO) new_y_s = Y_LAST;
        else                      new_y_s = seg_y_r[0] - Y_W'(1);
      end
      2'd1: begin
        if (seg_x_r[0] == X_LAST) new_x_s = X_ZERO;
        else                      new_x_s = seg_x_r[0] + X_W'(1);
      end
      2'd2: begin
        if (seg_y_r[0] == Y_LAST) new_y_s = Y_ZERO;
        else                      new_y_s = seg_y_r[0] + Y_W'(1);
      end
      2'd3: begin
        if (seg_x_r[0] == X_ZERO) new_x_s = X_LAST;
        else                      new_x_s = seg_x_r[0] - X_W'(1);
      end
      default: begin
        new_x_s = seg_x_r[0];
        new_y_s = seg_y_r[0];
      end
    endcase
  end

`ifdef SNAKE_WALL_KILL_EN
  logic wrap_s;

  // Edge detection: the pending move would cross the grid boundary.
  always_comb begin
    case (heading_nxt_s)
      2'd0:    wrap_s = (seg_y_r[0] == Y_ZERO);
      2'd1:    wrap_s = (seg_x_r[0] == X_LAST);
      2'd2:    wrap_s = (seg_y_r[0] == Y_LAST);
      2'd3:    wrap_s = (seg_x_r[0] == X_ZERO);
      default: wrap_s = 1'b0;
    endcase
  end

  assign wall_kill_s = wrap_s;
`else
  assign wall_kill_s = 1'b0;
`endif

  assign hit_target_s = (new_x_s == TARGET_X) && (new_y_s == TARGET_Y);
  assign scan_hit_s   = (seg_x_r[idx_r] == seg_x_r[0]) && (seg_y_r[idx_r] == seg_y_r[0]);
  assign scan_last_s  = (6'(idx_r) == (length_r - 6'd1));

  // Body store and RUN/SCAN/DEAD control.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_r[i] <= X_START;
        seg_y_r[i] <= Y_START;
      end
      heading_r    <= 2'd1;
      length_r     <= LEN_INIT;
      idx_r        <= {IDX_W{1'b0}};
      state_r      <= ST_RUN;
      busy_r       <= 1'b0;
      game_over_r  <= 1'b0;
      target_hit_r <= 1'b0;
    end else begin
      target_hit_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (STEP) begin
            heading_r <= heading_nxt_s;
            if (wall_kill_s) begin
              state_r     <= ST_DEAD;
              game_over_r <= 1'b1;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_r[i] <= seg_x_r[i-1];
                seg_y_r[i] <= seg_y_r[i-1];
              end
              seg_x_r[0] <= new_x_s;
              seg_y_r[0] <= new_y_s;
              if (hit_target_s) begin
                target_hit_r <= 1'b1;
                if (length_r != LEN_MAX) length_r <= length_r + 6'd1;
              end
              idx_r   <= IDX_W'(1);
              state_r <= ST_SCAN;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (scan_hit_s) begin
            state_r     <= ST_DEAD;
            busy_r      <= 1'b0;
            game_over_r <= 1'b1;
          end else if (scan_last_s) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        ST_DEAD: begin
          busy_r      <= 1'b0;
          game_over_r <= 1'b1;
        end
        default: begin
          state_r <= ST_RUN;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pix_cx_s  = PIX_X >> CELL_SHIFT;
  assign pix_cy_s  = PIX_Y >> CELL_SHIFT;
  assign in_grid_s = (pix_cx_s < 10'(GRID_W)) && (pix_cy_s < 9'(GRID_H));

  // Pixel hit test over the live segments only.
  always_comb begin
    pix_hit_s = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      pix_hit_s = pix_hit_s | ((6'(i) < length_r) &&
                               (pix_cx_s == 10'(seg_x_r[i])) &&
                               (pix_cy_s == 9'(seg_y_r[i])));
    end
  end

  // Registered render output, independent of FSM state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pix_on_r <= 1'b0;
    end else begin
      pix_on_r <= pix_hit_s && in_grid_s;
    end
  end

  assign PIX_ON         = pix_on_r;
  assign HEAD_X         = seg_x_r[0];
  assign HEAD_Y         = seg_y_r[0];
  assign LENGTH         = length_r;
  assign TARGET_REACHED = target_hit_r;
  assign BUSY           = busy_r;
  assign GAME_OVER      = game_over_r;

endmodule

// File: tb/tb_snake_body_engine.sv
// Self-checking bench for snake_body_engine: movement, wrap, growth, collision and render.
module tb_snake_body_engine;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       STEP = 1'b0;
  logic [1:0] DIRECTION = 2'd1;
  logic [7:0] TARGET_X = 8'd10;
  logic [6:0] TARGET_Y = 7'd10;
  logic [9:0] PIX_X = 10'd0;
  logic [8:0] PIX_Y = 9'd0;
  logic       PIX_ON;
  logic [7:0] HEAD_X;
  logic [6:0] HEAD_Y;
  logic [5:0] LENGTH;
  logic       TARGET_REACHED;
  logic       BUSY;
  logic       GAME_OVER;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_q[$];

  typedef struct {
    string      name;
    logic [9:0] px;
    logic [8:0] py;
    logic       exp_on;
  } pix_vec_t;

  pix_vec_t vecs[8];

  snake_body_engine dut (
    .CLK(CLK), .RESET(RESET), .STEP(STEP), .DIRECTION(DIRECTION),
    .TARGET_X(TARGET_X), .TARGET_Y(TARGET_Y), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .PIX_ON(PIX_ON), .HEAD_X(HEAD_X), .HEAD_Y(HEAD_Y), .LENGTH(LENGTH),
    .TARGET_REACHED(TARGET_REACHED), .BUSY(BUSY), .GAME_OVER(GAME_OVER)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && BUSY; n++) tick();
    check("scan_done", BUSY, 0);
  endtask

  task automatic do_step(input logic [1:0] dir);
    DIRECTION = dir;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    wait_idle();
  endtask

  task automatic step_tr(input logic [1:0] dir, input logic exp_tr, input string nm);
    DIRECTION = dir;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    check({nm, "_tr_pulse"}, TARGET_REACHED, exp_tr);
    tick();
    check({nm, "_tr_clear"}, TARGET_REACHED, 0);
    wait_idle();
  endtask

  task automatic render_check(input string nm, input logic [9:0] px, input logic [8:0] py,
                              input logic exp_on);
    PIX_X = px;
    PIX_Y = py;
    exp_q.push_back(exp_on);
    tick();
    check(nm, PIX_ON, exp_q.pop_front());
  endtask

  initial begin
    vecs[0] = '{"pix_head83",    10'd332, 9'd240, 1'b1};
    vecs[1] = '{"pix_past_head", 10'd336, 9'd240, 1'b0};
    vecs[2] = '{"pix_seg82",     10'd328, 9'd240, 1'b1};
    vecs[3] = '{"pix_seg81",     10'd325, 9'd241, 1'b1};
    vecs[4] = '{"pix_tail80",    10'd323, 9'd243, 1'b1};
    vecs[5] = '{"pix_gone79",    10'd316, 9'd240, 1'b0};
    vecs[6] = '{"pix_row61",     10'd332, 9'd244, 1'b0};
    vecs[7] = '{"pix_offgrid",   10'd700, 9'd240, 1'b0};

    // Reset state
    do_reset();
    check("rst_head_x", HEAD_X, 80);
    check("rst_head_y", HEAD_Y, 60);
    check("rst_length", LENGTH, 4);
    check("rst_busy", BUSY, 0);
    check("rst_game_over", GAME_OVER, 0);
    check("rst_pix_on", PIX_ON, 0);
    check("rst_tr", TARGET_REACHED, 0);

    // Three steps right, then render table against the body 83..80
    for (int k = 0; k < 3; k++) do_step(2'd1);
    check("move3_head_x", HEAD_X, 83);
    check("move3_head_y", HEAD_Y, 60);
    check("move3_length", LENGTH, 4);
    check("move3_game_over", GAME_OVER, 0);
    foreach (vecs[i]) render_check(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].exp_on);

    // Right-edge wrap
    do_reset();
    for (int k = 0; k < 79; k++) do_step(2'd1);
    check("edge_head_x", HEAD_X, 159);
    do_step(2'd1);
`ifdef SNAKE_WALL_KILL_EN
    check("wallx_head_x", HEAD_X, 159);
    check("wallx_game_over", GAME_OVER, 1);
`else
    check("wrapx_head_x", HEAD_X, 0);
    check("wrapx_game_over", GAME_OVER, 0);
`endif
    check("wrapx_head_y", HEAD_Y, 60);

    // Top-edge wrap
    do_reset();
    for (int k = 0; k < 60; k++) do_step(2'd0);
    check("edge_head_y", HEAD_Y, 0);
    do_step(2'd0);
`ifdef SNAKE_WALL_KILL_EN
    check("wally_head_y", HEAD_Y, 0);
    check("wally_game_over", GAME_OVER, 1);
`else
    check("wrapy_head_y", HEAD_Y, 119);
    check("wrapy_game_over", GAME_OVER, 0);
`endif

    // Target capture, growth and saturation
    TARGET_X = 8'd81;
    TARGET_Y = 7'd60;
    do_reset();
    step_tr(2'd1, 1'b1, "grow1");
    check("grow1_length", LENGTH, 5);
    for (int k = 0; k < 27; k++) begin
      TARGET_X = 8'(82 + k);
      do_step(2'd1);
    end
    check("grow_full_length", LENGTH, 32);
    check("grow_full_head_x", HEAD_X, 108);
    TARGET_X = 8'd109;
    step_tr(2'd1, 1'b1, "sat");
    check("sat_length", LENGTH, 32);
    check("sat_head_x", HEAD_X, 109);

    // Reversal ignored, perpendicular turn taken
    TARGET_X = 8'd10;
    TARGET_Y = 7'd10;
    do_reset();
    do_step(2'd3);
    check("rev_head_x", HEAD_X, 81);
    check("rev_head_y", HEAD_Y, 60);
    do_step(2'd0);
    check("turn_head_x", HEAD_X, 81);
    check("turn_head_y", HEAD_Y, 59);

    // STEP during SCAN is dropped
    do_reset();
    DIRECTION = 2'd1;
    STEP = 1'b1;
    tick();
    check("drop_busy", BUSY, 1);
    tick();
    STEP = 1'b0;
    wait_idle();
    check("drop_head_x", HEAD_X, 81);

    // Self-collision that also lands on the target
    TARGET_X = 8'd81;
    TARGET_Y = 7'd60;
    do_reset();
    step_tr(2'd1, 1'b1, "col_grow");
    do_step(2'd1);
    do_step(2'd2);
    do_step(2'd3);
    check("col_pre_game_over", GAME_OVER, 0);
    step_tr(2'd0, 1'b1, "col_hit");
    check("col_game_over", GAME_OVER, 1);
    check("col_length", LENGTH, 6);
    do_step(2'd1);
    check("dead_head_x", HEAD_X, 81);
    check("dead_head_y", HEAD_Y, 60);
    check("dead_game_over", GAME_OVER, 1);
    render_check("dead_pix_seg", 10'd324, 9'd244, 1'b1);
    render_check("dead_pix_off", 10'd332, 9'd240, 1'b0);
    do_reset();
    check("revive_game_over", GAME_OVER, 0);
    check("revive_length", LENGTH, 4);

    // Reset in the middle of a scan
    DIRECTION = 2'd1;
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    check("midscan_busy", BUSY, 1);
    check("midscan_length", LENGTH, 5);
    do_reset();
    check("midscan_rst_busy", BUSY, 0);
    check("midscan_rst_length", LENGTH, 4);
    check("midscan_rst_head_x", HEAD_X, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
